// File: rtl/axi4l_lsu_master.sv
// AXI4-Lite initiator for the core's single-outstanding load/store port.
// One read or write is in flight at a time; completion is a done pulse with error flag.
module axi4l_lsu_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [ADDR_W-1:0]   m_axi_awaddr,
    output logic [2:0]          m_axi_awprot,
    output logic                m_axi_awvalid,
    input  logic                m_axi_awready,
    output logic [DATA_W-1:0]   m_axi_wdata,
    output logic [DATA_W/8-1:0] m_axi_wstrb,
    output logic                m_axi_wvalid,
    input  logic                m_axi_wready,
    input  logic [1:0]          m_axi_bresp,
    input  logic                m_axi_bvalid,
    output logic                m_axi_bready,
    output logic [ADDR_W-1:0]   m_axi_araddr,
    output logic [2:0]          m_axi_arprot,
    output logic                m_axi_arvalid,
    input  logic                m_axi_arready,
    input  logic [DATA_W-1:0]   m_axi_rdata,
    input  logic [1:0]          m_axi_rresp,
    input  logic                m_axi_rvalid,
    output logic                m_axi_rready
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {IDLE, WREQ, WRESP, RREQ, RRESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;
    logic             aw_ok, w_ok;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // A channel is finished once its valid has dropped or its handshake is happening now.
    assign aw_ok       = !m_axi_awvalid || m_axi_awready;
    assign w_ok        = !m_axi_wvalid  || m_axi_wready;
    assign timeout_hit = (TIMEOUT > 0) && busy_o && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            rdata_o       <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            cnt    <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        if (we_i) begin
                            m_axi_awaddr  <= addr_i;
                            m_axi_wdata   <= wdata_i;
                            m_axi_wstrb   <= wstrb_i;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= WREQ;
                        end else begin
                            m_axi_araddr  <= addr_i;
                            m_axi_arvalid <= 1'b1;
                            state         <= RREQ;
                        end
                    end
                end
                WREQ: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if (aw_ok && w_ok) begin
                        m_axi_bready <= 1'b1;
                        state        <= WRESP;
                    end
                end
                WRESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                        err_o        <= |m_axi_bresp;
                        state        <= IDLE;
                    end
                end
                RREQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RRESP;
                    end
                end
                RRESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rdata_o      <= m_axi_rdata;
                        busy_o       <= 1'b0;
                        done_o       <= 1'b1;
                        err_o        <= |m_axi_rresp;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Abort wins over everything else; read data is left as it was.
            if (timeout_hit) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                busy_o        <= 1'b0;
                done_o        <= 1'b1;
                err_o         <= 1'b1;
                state         <= IDLE;
            end
        end
    end
endmodule
